// File: rtl/bcd_pkg.sv
// Constants shared by the BCD conversion blocks: FSM encoding, digit limits
// and the reverse double-dabble correction values.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGITS_DEF = 4;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Start/busy/done handshake bundle between BCD entry logic and the converter.
interface bcd2bin_seq_if #(
    parameter int BUS_WIDTH = 11,
    parameter int DIGITS    = bcd_pkg::DIGITS_DEF
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BUS_WIDTH:0]    bin;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (output start, bcd, input bin, busy, done, err);
    modport slave  (input start, bcd, output bin, busy, done, err);
endinterface

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: values of 8 or more lose 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= ADJ_THRESH) ? (d - ADJ_SUB) : d;
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one reverse double-dabble shift per cycle,
// with invalid-digit and output-overflow detection.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int BUS_WIDTH = 11,
    parameter int DIGITS    = DIGITS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    bcd2bin_seq_if.slave  bus
);
    localparam int AW = 4 * DIGITS;
    localparam int OW = BUS_WIDTH + 1;
    localparam int CW = (AW > 1) ? $clog2(AW) : 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   bcd_r, acc, bcd_sh, bcd_adj;
    logic [CW-1:0]   cnt;
    logic            inv, in_bad, last, ovf;
    logic [OW-1:0]   res, bin_q;
    logic            err_q, done_q;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bus.bcd[4*i +: 4] > DIGIT_MAX) in_bad = 1'b1;
    end

    assign last   = (cnt == CW'(AW - 1));
    assign bcd_sh = bcd_r >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.d(bcd_sh[4*g +: 4]), .q(bcd_adj[4*g +: 4]));
    end

    // Only a narrower output can overflow; 4*DIGITS bits always hold the value.
    if (OW < AW) begin : g_ovf
        assign ovf = |acc[AW-1:OW];
    end else begin : g_no_ovf
        assign ovf = 1'b0;
    end
    assign res = OW'(acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = in_bad ? DONE : SHIFT;
            SHIFT:   if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == SHIFT) || (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_r <= '0;
            acc   <= '0;
            cnt   <= '0;
            inv   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            bcd_r <= bus.bcd;
            acc   <= '0;
            cnt   <= '0;
            inv   <= in_bad;
        end else if (state == SHIFT) begin
            acc   <= {bcd_r[0], acc[AW-1:1]};
            bcd_r <= bcd_adj;
            cnt   <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == DONE);
            if (state == DONE) begin
                if (inv || ovf) begin
                    bin_q <= '0;
                    err_q <= 1'b1;
                end else begin
                    bin_q <= res;
                    err_q <= 1'b0;
                end
            end
        end
    end

    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Bench for bcd2bin_seq: two instances (12-bit and 14-bit outputs) share one
// stimulus stream and are compared against an arithmetic BCD decode model.
module tb_bcd2bin_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bcd = '0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bcd2bin_seq_if #(.BUS_WIDTH(11), .DIGITS(4)) b11 ();
    bcd2bin_seq_if #(.BUS_WIDTH(13), .DIGITS(4)) b13 ();

    assign b11.start = start;
    assign b11.bcd   = bcd;
    assign b13.start = start;
    assign b13.bcd   = bcd;

    bcd2bin_seq #(.BUS_WIDTH(11), .DIGITS(4)) dut11 (.clk(clk), .rst_n(rst_n), .bus(b11));
    bcd2bin_seq #(.BUS_WIDTH(13), .DIGITS(4)) dut13 (.clk(clk), .rst_n(rst_n), .bus(b13));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit bad_digit(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // Returns {err, bin}: decimal value of the digits, or err when a digit is
    // not decimal or the value needs more than ow bits.
    function automatic logic [31:0] model(input logic [15:0] v, input int ow);
        int val = 0;
        int p   = 1;
        if (bad_digit(v)) return 32'h8000_0000;
        for (int i = 0; i < 4; i++) begin
            val += int'(v[4*i +: 4]) * p;
            p   *= 10;
        end
        if (val >= (1 << ow)) return 32'h8000_0000;
        return 32'(val);
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        int          x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!b11.done && cyc < 40);
    endtask

    task automatic run(input string tag, input logic [15:0] v);
        logic [31:0] m11, m13;
        int          cyc;
        m11 = model(v, 12);
        m13 = model(v, 14);
        @(negedge clk);
        start = 1'b1;
        bcd   = v;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_acc"}, 32'(b11.busy), 32'd1);
        wait_done(cyc);
        check({tag, ":latency"}, 32'(cyc), bad_digit(v) ? 32'd1 : 32'd17);
        check({tag, ":done13"}, 32'(b13.done), 32'd1);
        check({tag, ":busy_done"}, 32'(b11.busy), 32'd0);
        check({tag, ":bin11"}, 32'(b11.bin), {1'b0, m11[30:0]});
        check({tag, ":err11"}, 32'(b11.err), 32'(m11[31]));
        check({tag, ":bin13"}, 32'(b13.bin), {1'b0, m13[30:0]});
        check({tag, ":err13"}, 32'(b13.err), 32'(m13[31]));
        @(posedge clk); #1;
        check({tag, ":done_pulse"}, 32'(b11.done), 32'd0);
        check({tag, ":bin_hold"}, 32'(b13.bin), {1'b0, m13[30:0]});
    endtask

    initial begin
        int          cyc;
        bit          seen;
        int          n;
        logic [15:0] v;

        #3 rst_n = 1'b0;
        #1;
        check("rst:bin", 32'(b11.bin), 32'd0);
        check("rst:err", 32'(b11.err), 32'd0);
        check("rst:done", 32'(b11.done), 32'd0);
        check("rst:busy", 32'(b13.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run("z0000", 16'h0000);
        run("v4095", 16'h4095);
        run("v4096", 16'h4096);
        run("v9999", 16'h9999);
        run("inv12A4", 16'h12A4);

        // start held high every edge; a new code mid-conversion must be ignored
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h0123;
        @(posedge clk); #1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i == 5) bcd = 16'h0456;
        end
        check("b2b:done1", 32'(b11.done), 32'd1);
        check("b2b:bin1", 32'(b11.bin), 32'd123);
        bcd = 16'h0789;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("b2b:lat2", 32'(cyc), 32'd17);
        check("b2b:bin2", 32'(b13.bin), 32'd789);

        // reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bcd   = 16'h0999;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort:bin", 32'(b11.bin), 32'd0);
        check("abort:busy", 32'(b11.busy), 32'd0);
        check("abort:done", 32'(b13.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (b11.done || b13.done) seen = 1'b1;
        end
        check("abort:no_done", 32'(seen), 32'd0);
        run("v0042", 16'h0042);

        for (int k = 0; k < 150; k++) begin
            n = int'($urandom_range(0, 9999));
            run("rnd", to_bcd(n));
            check("rnd:sweep13", 32'(b13.bin), 32'(n));
        end
        for (int k = 0; k < 30; k++) begin
            v = 16'($urandom);
            run("rndraw", v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
